// File: rtl/logic_gate_unit.sv
// Pipelined bitwise logic unit: one of eight gate operations on two WIDTH-bit operands,
// carried through a LATENCY-deep valid pipeline with global stall, reduction flags and a saturating hand-off counter.
module logic_gate_unit #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               red_and,
    output logic               red_or,
    output logic               red_xor,
    output logic               zero,
    output logic [COUNT_W-1:0] done_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0] result_c;
    logic             stall;
    logic             handoff;

    // Gate result from the operands presented this cycle; captured into the first stage on acceptance.
    always_comb begin
        result_c = '0;
        case (op)
            3'b000:  result_c = a & b;
            3'b001:  result_c = a | b;
            3'b010:  result_c = a ^ b;
            3'b011:  result_c = ~(a & b);
            3'b100:  result_c = ~(a | b);
            3'b101:  result_c = ~(a ^ b);
            3'b110:  result_c = ~a;
            default: result_c = a;
        endcase
    end

    // Every stage freezes together while the final result waits for the consumer.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign handoff  = out_valid && out_ready;

    for (genvar i = 0; i < int'(LATENCY); i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        if (i == 0) begin : g_head
            assign d_in = result_c;
            assign v_in = in_valid;
        end else begin : g_tail
            assign d_in = g_stage[i-1].data_q;
            assign v_in = g_stage[i-1].valid_q;
        end

        // Bubbles advance like items so spacing between results is preserved.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (!stall) begin
                data_q  <= d_in;
                valid_q <= v_in;
            end
        end
    end

    assign out       = g_stage[LATENCY-1].data_q;
    assign out_valid = g_stage[LATENCY-1].valid_q;

    assign red_and = &out;
    assign red_or  = |out;
    assign red_xor = ^out;
    assign zero    = ~red_or;

    // Completed-result counter sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count <= '0;
        end else if (handoff && (done_count != COUNT_MAX)) begin
            done_count <= done_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed vector table, corner-case sequences and a
// randomized stream checked against an in-order scoreboard built from per-bit gate truth tables.
module tb_logic_gate_unit;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 2;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic [2:0]    op;
    logic          in_valid, in_ready;
    logic [W-1:0]  out;
    logic          out_valid, out_ready;
    logic          red_and, red_or, red_xor, zero;
    logic [CW-1:0] done_count;

    logic [W-1:0]  s_a, s_b;
    logic [2:0]    s_op;
    logic          s_in_valid, s_in_ready;
    logic [W-1:0]  s_out;
    logic          s_out_valid, s_out_ready;
    logic          s_red_and, s_red_or, s_red_xor, s_zero;
    logic [1:0]    s_done_count;

    logic_gate_unit #(.WIDTH(W), .LATENCY(L), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .red_and(red_and), .red_or(red_or), .red_xor(red_xor), .zero(zero),
        .done_count(done_count)
    );

    // Second instance: single-stage pipeline with a 2-bit counter for the saturation sequence.
    logic_gate_unit #(.WIDTH(W), .LATENCY(1), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(s_a), .b(s_b), .op(s_op),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out(s_out), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .red_and(s_red_and), .red_or(s_red_or), .red_xor(s_red_xor), .zero(s_zero),
        .done_count(s_done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         r_and;
        logic         r_or;
        logic         r_xor;
        logic         zero;
    } vec_t;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    int           model_cnt = 0;
    logic         mon_en = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_out = '0;
    logic         last_acc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Gate behaviour as a 4-entry truth table per operation, indexed by {a_bit, b_bit}.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (o)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < int'(W); i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < int'(W); i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out"}, 64'(out), 64'(0));
        check({tag, "_zero"}, 64'(zero), 64'(1));
        check({tag, "_red_and"}, 64'(red_and), 64'(0));
        check({tag, "_red_or"}, 64'(red_or), 64'(0));
        check({tag, "_red_xor"}, 64'(red_xor), 64'(0));
        check({tag, "_done_count"}, 64'(done_count), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    // One clock: scoreboard sampling on the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (mon_en) begin
            if (prev_stall) check("stall_hold_out", 64'(out), 64'(prev_out));
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            check("done_count_model", 64'(done_count), 64'(model_cnt));
            if (out_valid) begin
                check("flag_and", 64'(red_and), 64'(ones(out) == int'(W)));
                check("flag_or", 64'(red_or), 64'(ones(out) != 0));
                check("flag_xor", 64'(red_xor), 64'(ones(out) % 2));
                check("flag_zero", 64'(zero), 64'(ones(out) == 0));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_result", 64'(1), 64'(0));
                else check("result_data", 64'(out), 64'(exp_q.pop_front()));
                if (model_cnt < (1 << CW) - 1) model_cnt++;
            end
            if (last_acc) exp_q.push_back(ref_op(a, b, op));
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        model_cnt  = 0;
        prev_stall = 1'b0;
    endtask

    vec_t tv[12];
    int   pat[6];

    initial begin
        rst_n = 1'b0; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
        s_a = '0; s_b = '0; s_op = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;

        // Reset state
        #12;
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        mon_en = 1'b1;

        // Truth table and flag vectors, streamed back to back
        tv[0]  = '{8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{8'hF0, 8'hCC, 3'd1, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{8'hF0, 8'hCC, 3'd2, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{8'hF0, 8'hCC, 3'd3, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{8'hF0, 8'hCC, 3'd4, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{8'hF0, 8'hCC, 3'd5, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{8'hF0, 8'hCC, 3'd6, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{8'hF0, 8'hCC, 3'd7, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[8]  = '{8'hFF, 8'hFF, 3'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{8'hFF, 8'hFF, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[10] = '{8'h01, 8'h55, 3'd6, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[11] = '{8'h80, 8'h00, 3'd7, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 12 + int'(L); c++) begin
            int idx;
            if (c < 12) begin
                a = tv[c].a; b = tv[c].b; op = tv[c].op; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            idx = c - (int'(L) - 1);
            if (idx >= 0 && idx < 12) begin
                check("tt_valid", 64'(out_valid), 64'(1));
                check("tt_out", 64'(out), 64'(tv[idx].res));
                check("tt_red_and", 64'(red_and), 64'(tv[idx].r_and));
                check("tt_red_or", 64'(red_or), 64'(tv[idx].r_or));
                check("tt_red_xor", 64'(red_xor), 64'(tv[idx].r_xor));
                check("tt_zero", 64'(zero), 64'(tv[idx].zero));
            end else begin
                check("tt_idle_valid", 64'(out_valid), 64'(0));
            end
        end

        // Bubbles keep their spacing through the pipeline
        pat = '{1, 0, 1, 0, 0, 0};
        for (int c = 0; c < 6; c++) begin
            int idx;
            in_valid = (pat[c] != 0);
            a = 8'(8'h11 * c); b = 8'h5A; op = 3'(c);
            tick();
            idx = c - (int'(L) - 1);
            check("bubble_valid", 64'(out_valid), 64'((idx >= 0) ? pat[idx] : 0));
        end

        // Asynchronous reset mid-stream with two items in flight
        for (int c = 0; c < 2; c++) begin
            a = 8'(8'h3C + c); b = 8'hA5; op = 3'(c + 1); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        clear_model();
        tick();
        rst_n = 1'b1;

        // Backpressure: four items, consumer stalls three cycles while the first is valid
        begin
            int   sent = 0;
            int   stall_left = -1;
            for (int c = 0; c < 40 && !(sent == 4 && done_count == 4); c++) begin
                if (sent < 4) begin
                    a = 8'(8'h21 * (sent + 1)); b = 8'h96; op = 3'(sent + 2); in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                if (stall_left < 0 && out_valid) stall_left = 3;
                out_ready = !(stall_left > 0);
                #1;
                if (stall_left > 0) check("bp_in_ready_low", 64'(in_ready), 64'(0));
                tick();
                if (last_acc) sent++;
                if (stall_left > 0) stall_left--;
            end
            in_valid = 1'b0; out_ready = 1'b1;
            check("bp_sent", 64'(sent), 64'(4));
            check("bp_done_count", 64'(done_count), 64'(4));
            check("bp_queue_empty", 64'(exp_q.size()), 64'(0));
        end

        // Randomized stream with random backpressure; offered operands held until accepted
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < int'(L) + 2; c++) tick();
        check("rand_queue_empty", 64'(exp_q.size()), 64'(0));
        check("rand_count", 64'(done_count), 64'(model_cnt));

        // Saturating 2-bit counter on the single-stage instance
        for (int c = 0; c < 6; c++) begin
            s_in_valid = (c < 5);
            s_a = 8'(c * 37 + 5); s_b = 8'(c * 11 + 3); s_op = 3'(c);
            tick();
            check("sat_count", 64'(s_done_count), 64'((c < 3) ? c : 3));
            if (c < 5) begin
                check("sat_valid", 64'(s_out_valid), 64'(1));
                check("sat_out", 64'(s_out), 64'(ref_op(8'(c * 37 + 5), 8'(c * 11 + 3), 3'(c))));
            end else begin
                check("sat_idle_valid", 64'(s_out_valid), 64'(0));
            end
        end
        s_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, pipelined bitwise logic unit: the next generation of the team's two-input gate primitives. It applies one of eight selectable bitwise operations to two WIDTH-bit operands and registers the result through a LATENCY-deep pipeline with valid/ready flow control and backpressure. It also produces reduction flags and a saturating completed-result counter. It sits between a stimulus/packet source and any consumer that needs gate results in lock-step with a data stream.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..64.
- LATENCY, 2: number of pipeline stages from acceptance to result; legal range 1..4.
- COUNT_W, 16: width of the completed-result counter.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous, release is synchronous to clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for ops 110 and 111.
- op  input  3  operation select; captured together with a and b.
- in_valid  input  1  a, b and op are valid this cycle.
- in_ready  output  1  unit can accept an operand set this cycle.
- out  output  WIDTH  result.
- out_valid  output  1  out and all flags are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- red_and  output  1  AND-reduction of out.
- red_or  output  1  OR-reduction of out.
- red_xor  output  1  XOR-reduction (parity) of out.
- zero  output  1  out is all zeros; equal to ~red_or.
- done_count  output  COUNT_W  number of results handed off; saturating.

## Operation
- op encoding:
  - 000 AND: a&b
  - 001 OR: a|b
  - 010 XOR: a^b
  - 011 NAND: ~(a&b)
  - 100 NOR: ~(a|b)
  - 101 XNOR: ~(a^b)
  - 110 NOT: ~a
  - 111 BUF: a
- Acceptance: a transfer occurs on a rising edge with in_valid && in_ready.
- The result is computed combinationally from the captured operands and op, then carried through LATENCY stages.
  - Each stage holds a data register and a valid bit.
- Global stall: stall = out_valid && !out_ready.
  - While stall is high, every stage holds, including its valid bit.
  - in_ready = !stall. in_ready is combinational from out_valid and out_ready.
- No stall: every stage advances each cycle. Bubbles (invalid stages) propagate and are never compressed.
- Flags are derived combinationally from the final-stage data. They are meaningful only while out_valid is high.
- done_count increments by 1 on each edge with out_valid && out_ready.
  - It holds at 2^COUNT_W-1 once reached; it does not wrap.
- No state machine beyond the valid pipeline; operation is stateless per item.

## Timing
- Reset values:
  - All stage valid bits, out_valid and done_count are 0.
  - out is 0, so red_and=0, red_or=0, red_xor=0 and zero=1.
  - in_ready is 1.
- Latency: an item accepted at edge N appears with out_valid=1 after edge N+LATENCY-1. With LATENCY=1, it is valid in the cycle after acceptance. Latency holds only if no stall occurs in between.
- Throughput: one item per cycle while out_ready is held high.
- Stall: out and the flags stay stable while out_valid && !out_ready. The item is not lost or duplicated.
- in_valid together with a stall: no acceptance. The source must hold a, b and op until in_ready returns.
- Accept and hand-off on the same edge: both happen. Capture and counter increment occur together.
- out_valid=0 with out_ready=1: no counter change; the pipeline advances.
- Reset mid-stream: all in-flight items are discarded immediately (asynchronous) and done_count clears. No partial result is ever presented with out_valid=1.
- WIDTH=1: all reductions equal out; zero=~out.

## Test plan
- Reset check: assert rst_n=0 mid-cycle with 2 items in flight. Required response: out_valid falls immediately; out=0, zero=1, done_count=0, in_ready=1.
- Truth table (WIDTH=8, LATENCY=2, out_ready=1): a=8'hF0, b=8'hCC, ops 000..111 on consecutive cycles. Required outputs in order: C0, FC, 3C, 3F, 03, C3, 0F, F0, with the first result valid after the second edge following acceptance. red_xor for C0=0; red_and for 03=0.
- Backpressure: stream 4 items and drop out_ready for 3 cycles while the first is valid. Required response: out holds steady, in_ready=0, no item is lost or duplicated, and done_count ends at 4.
- Bubbles: toggle in_valid 1,0,1. Required response: out_valid shows the same 1,0,1 pattern shifted by LATENCY.
- Saturation (COUNT_W=2): 5 hand-offs. Required response: done_count reads 1, 2, 3, 3, 3.
- Flags: a=b=8'hFF with op=000 gives red_and=1 and zero=0. op=010 gives out=00, zero=1 and red_or=0.
